vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Display-side consumer of the VRAM that the game state controller fills.
- Generates 640x480@60 VGA timing from the 100 MHz system clock.
- Walks the VRAM in raster order one pixel ahead and converts each cell bit to RGB444.
- Flags the start of vertical blanking, so the controller can schedule its VRAM copy.

Parameters:
- ACTIVE_COLUMNS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), VRAM address width
- DATA_WIDTH, 1, VRAM word width; nonzero word = sand
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch/sync widths in pixels
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch/sync heights in lines
- CLKS_PER_PIXEL, 4, clk_i cycles per pixel; must be >= 2
- SAND_RGB, 12'hFC4, colour for a nonzero cell; an empty cell is 12'h000

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- vram_read_data_i  in  DATA_WIDTH  VRAM synchronous read data, 1-cycle latency
- vram_read_address_o  out  ADDR_WIDTH  VRAM read address (registered)
- hsync_o  out  1  horizontal sync, active low
- vsync_o  out  1  vertical sync, active low
- video_on_o  out  1  high while rgb_o carries a visible pixel
- rgb_o  out  12  RGB444 pixel
- vblank_start_o  out  1  one-clk pulse when vertical blanking begins
- test_pattern_i  in  1  checkerboard select (used only with VGA_TEST_PATTERN_EN)

Behaviour:
- Reset (async assert, sync release):
  - All counters cleared.
  - hsync_o=1, vsync_o=1, video_on_o=0, rgb_o=0, vram_read_address_o=0, vblank_start_o=0.
  - Reset mid-frame restarts at pixel (0,0) with no partial-line artefacts beyond the reset cycle.
- Pixel tick:
  - Divider counts 0..CLKS_PER_PIXEL-1.
  - tick = (divider == CLKS_PER_PIXEL-1).
  - All state below advances only on tick.
- Counters:
  - H_TOTAL = ACTIVE_COLUMNS+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = ACTIVE_ROWS+V_FRONT+V_SYNC+V_BACK (525).
  - h wraps H_TOTAL-1 -> 0 and increments v; v wraps V_TOTAL-1 -> 0.
- Address stage:
  - On tick, vram_read_address_o loads the address of the next counter position (h', v'), computed as an incremental running counter (no multiplier).
  - The running counter resets to 0 when (h', v') = (0, 0).
  - It advances by 1 only when (h', v') is inside the active area; otherwise it holds.
- Output stage (one pixel after counters):
  - On tick, hsync_o, vsync_o and video_on_o register the decode of the current (h, v).
  - hsync_o is low for h in [ACTIVE_COLUMNS+H_FRONT, ACTIVE_COLUMNS+H_FRONT+H_SYNC).
  - vsync_o is low for v in the analogous vertical window.
  - rgb_o = active ? (vram_read_data_i != 0 ? SAND_RGB : 0) : 0.
  - VRAM data is sampled CLKS_PER_PIXEL-1 >= 1 cycles after its address, so latency is met.
  - Timing and colour for one pixel always change on the same clk edge.
- vblank_start_o: single-clk pulse on the tick where the counters move to (0, ACTIVE_ROWS). Never asserted more than once per frame.
- No handshake; the block free-runs. The VRAM is read-only from this side; no write ports.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined and test_pattern_i=1: active pixels show a 16x16-pixel checkerboard, with SAND_RGB where (h[4]^v[4])=1 and 0 otherwise. The VRAM is still addressed but its data is ignored. Sync and vblank timing are unchanged.
- When undefined: test_pattern_i is unused (tie-off tolerated) and there is no checkerboard logic.

Test Plan:
- Reset, then run with default params -> hsync_o period 3200 clks, low for 384 clks; vsync_o period 1,680,000 clks, low for 6400 clks.
- Preload VRAM with 1 at address 0 and address 641 only -> rgb_o=12'hFC4 exactly at visible pixels (0,0) and (1,1); every other visible pixel =0; all blanking pixels =0 with video_on_o=0.
- Monitor vram_read_address_o over one frame -> takes values 0..307199 in order, each exactly once; holds during blanking; returns to 0 before the next visible pixel (0,0).
- Check vblank_start_o -> exactly one 1-clk pulse per frame; it coincides with the counters moving to (0,480), 384,000 pixels after the frame start.
- Deassert reset_ni mid-line (h=300, v=200), then re-assert -> outputs go to reset values immediately; the next frame starts at (0,0) with correct sync timing.
- With VGA_TEST_PATTERN_EN defined, test_pattern_i=1 and VRAM all 0 -> pixels (0,0)=0, (16,0)=12'hFC4, (16,16)=0.

Source files
------------

// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 raster reader: walks VRAM one pixel ahead of the output stage and
// converts each cell to RGB444. Optional checkerboard overlay under VGA_TEST_PATTERN_EN.
module vga_frame_reader #(
   parameter int          ACTIVE_COLUMNS = 640,
   parameter int          ACTIVE_ROWS    = 480,
   parameter int          ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
   parameter int          DATA_WIDTH     = 1,
   parameter int          H_FRONT        = 16,
   parameter int          H_SYNC         = 96,
   parameter int          H_BACK         = 48,
   parameter int          V_FRONT        = 10,
   parameter int          V_SYNC         = 2,
   parameter int          V_BACK         = 33,
   parameter int          CLKS_PER_PIXEL = 4,
   parameter logic [11:0] SAND_RGB       = 12'hFC4
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [DATA_WIDTH-1:0] vram_read_data_i,
   output logic [ADDR_WIDTH-1:0] vram_read_address_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  video_on_o,
   output logic [11:0]           rgb_o,
   output logic                  vblank_start_o,
   input  logic                  test_pattern_i
);

   localparam int H_TOTAL = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int DIV_W   = $clog2(CLKS_PER_PIXEL);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_PIXEL - 1);
   localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [H_W-1:0]   H_ACT    = H_W'(ACTIVE_COLUMNS);
   localparam logic [V_W-1:0]   V_ACT    = V_W'(ACTIVE_ROWS);
   localparam logic [H_W-1:0]   HS_START = H_W'(ACTIVE_COLUMNS + H_FRONT);
   localparam logic [H_W-1:0]   HS_END   = H_W'(ACTIVE_COLUMNS + H_FRONT + H_SYNC);
   localparam logic [V_W-1:0]   VS_START = V_W'(ACTIVE_ROWS + V_FRONT);
   localparam logic [V_W-1:0]   VS_END   = V_W'(ACTIVE_ROWS + V_FRONT + V_SYNC);

   logic [DIV_W-1:0]      div_count;
   logic                  tick;
   logic [H_W-1:0]        h_count;
   logic [V_W-1:0]        v_count;
   logic [H_W-1:0]        h_next;
   logic [V_W-1:0]        v_next;
   logic                  active_cur;
   logic                  active_next;
   logic                  hsync_window;
   logic                  vsync_window;
   logic [11:0]           pixel_rgb;

   assign tick = (div_count == DIV_LAST);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         div_count <= '0;
      end else if (tick) begin
         div_count <= '0;
      end else begin
         div_count <= div_count + 1'b1;
      end
   end

   always_comb begin
      h_next = h_count + 1'b1;
      v_next = v_count;
      if (h_count == H_LAST) begin
         h_next = '0;
         v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end
   end

   assign active_cur   = (h_count < H_ACT) && (v_count < V_ACT);
   assign active_next  = (h_next < H_ACT) && (v_next < V_ACT);
   assign hsync_window = (h_count >= HS_START) && (h_count < HS_END);
   assign vsync_window = (v_count >= VS_START) && (v_count < VS_END);

   // The address register always holds the VRAM index of the current (h, v), so the
   // read data is settled well before the output stage consumes it on the next tick.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         h_count             <= '0;
         v_count             <= '0;
         vram_read_address_o <= '0;
      end else if (tick) begin
         h_count <= h_next;
         v_count <= v_next;
         if ((h_next == '0) && (v_next == '0)) begin
            vram_read_address_o <= '0;
         end else if (active_next) begin
            vram_read_address_o <= vram_read_address_o + 1'b1;
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   always_comb begin
      pixel_rgb = '0;
      if (active_cur) begin
         if (test_pattern_i) begin
            pixel_rgb = (h_count[4] ^ v_count[4]) ? SAND_RGB : 12'h000;
         end else begin
            pixel_rgb = (vram_read_data_i != '0) ? SAND_RGB : 12'h000;
         end
      end
   end
`else
   logic unused_test_pattern;
   assign unused_test_pattern = test_pattern_i;

   always_comb begin
      pixel_rgb = '0;
      if (active_cur) begin
         pixel_rgb = (vram_read_data_i != '0) ? SAND_RGB : 12'h000;
      end
   end
`endif

   // Sync, blank and colour all register together so one pixel changes on one edge.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         hsync_o        <= 1'b1;
         vsync_o        <= 1'b1;
         video_on_o     <= 1'b0;
         rgb_o          <= '0;
         vblank_start_o <= 1'b0;
      end else begin
         vblank_start_o <= tick && (h_next == '0) && (v_next == V_ACT);
         if (tick) begin
            hsync_o    <= ~hsync_window;
            vsync_o    <= ~vsync_window;
            video_on_o <= active_cur;
            rgb_o      <= pixel_rgb;
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader using a shrunken 8x4 raster (15x8 total)
// so whole frames fit in a few hundred clocks.
module tb_vga_frame_reader;

   localparam int COLS  = 8;
   localparam int ROWS  = 4;
   localparam int HFP   = 2;
   localparam int HSW   = 3;
   localparam int HBP   = 2;
   localparam int VFP   = 1;
   localparam int VSW   = 2;
   localparam int VBP   = 1;
   localparam int CPP   = 4;
   localparam int AW    = $clog2(COLS*ROWS);
   localparam int HTOT  = COLS + HFP + HSW + HBP;
   localparam int VTOT  = ROWS + VFP + VSW + VBP;
   localparam int FRAME_CLKS = HTOT * VTOT * CPP;

   logic          clk;
   logic          reset_n;
   logic [0:0]    rdata;
   logic [AW-1:0] addr;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic [11:0]   rgb;
   logic          vblank_start;
   logic          test_pattern;

   logic [0:0]    mem [0:COLS*ROWS-1];

   int total;
   int bad;
   int cur;

   typedef struct {
      int          h;
      int          v;
      logic        exp_video;
      logic        exp_hsync;
      logic        exp_vsync;
      logic [11:0] exp_rgb;
      int          exp_addr;
      logic        exp_vblank;
   } vec_t;

   vec_t vecs [16];

   vga_frame_reader #(
      .ACTIVE_COLUMNS(COLS),
      .ACTIVE_ROWS   (ROWS),
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (1),
      .H_FRONT       (HFP),
      .H_SYNC        (HSW),
      .H_BACK        (HBP),
      .V_FRONT       (VFP),
      .V_SYNC        (VSW),
      .V_BACK        (VBP),
      .CLKS_PER_PIXEL(CPP),
      .SAND_RGB      (12'hFC4)
   ) dut (
      .clk_i              (clk),
      .reset_ni           (reset_n),
      .vram_read_data_i   (rdata),
      .vram_read_address_o(addr),
      .hsync_o            (hsync),
      .vsync_o            (vsync),
      .video_on_o         (video_on),
      .rgb_o              (rgb),
      .vblank_start_o     (vblank_start),
      .test_pattern_i     (test_pattern)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rdata <= mem[addr];

   task automatic check_output(input string name, input int got, input int expected);
      total++;
      if (got != expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expected);
      end
   endtask

   // Output stage shows raster pixel cur after the tick at clock edge CPP*(cur+1).
   task automatic apply_stimulus(input int target);
      while (cur < target) begin
         repeat (CPP) @(posedge clk);
         @(negedge clk);
         cur++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, " hsync"}, int'(hsync), 1);
      check_output({tag, " vsync"}, int'(vsync), 1);
      check_output({tag, " video_on"}, int'(video_on), 0);
      check_output({tag, " rgb"}, int'(rgb), 0);
      check_output({tag, " addr"}, int'(addr), 0);
      check_output({tag, " vblank"}, int'(vblank_start), 0);
   endtask

   initial begin
      int prev_addr;
      int incs;
      int wraps;
      int jumps;
      int hs_low;
      int vs_low;
      int vb_count;

      total        = 0;
      bad          = 0;
      cur          = -1;
      reset_n      = 1'b0;
      test_pattern = 1'b0;
      for (int i = 0; i < COLS*ROWS; i++) mem[i] = 1'b0;
      mem[0] = 1'b1;
      mem[9] = 1'b1;

      //           h   v  vid hs vs rgb      addr vblank
      vecs[0]  = '{0,  0, 1, 1, 1, 12'hFC4, 1,  0};
      vecs[1]  = '{1,  0, 1, 1, 1, 12'h000, 2,  0};
      vecs[2]  = '{8,  0, 0, 1, 1, 12'h000, 7,  0};
      vecs[3]  = '{10, 0, 0, 0, 1, 12'h000, 7,  0};
      vecs[4]  = '{12, 0, 0, 0, 1, 12'h000, 7,  0};
      vecs[5]  = '{13, 0, 0, 1, 1, 12'h000, 7,  0};
      vecs[6]  = '{14, 0, 0, 1, 1, 12'h000, 8,  0};
      vecs[7]  = '{0,  1, 1, 1, 1, 12'h000, 9,  0};
      vecs[8]  = '{1,  1, 1, 1, 1, 12'hFC4, 10, 0};
      vecs[9]  = '{7,  3, 1, 1, 1, 12'h000, 31, 0};
      vecs[10] = '{14, 3, 0, 1, 1, 12'h000, 31, 1};
      vecs[11] = '{0,  4, 0, 1, 1, 12'h000, 31, 0};
      vecs[12] = '{0,  5, 0, 1, 0, 12'h000, 31, 0};
      vecs[13] = '{6,  6, 0, 1, 0, 12'h000, 31, 0};
      vecs[14] = '{3,  7, 0, 1, 1, 12'h000, 31, 0};
      vecs[15] = '{14, 7, 0, 1, 1, 12'h000, 0,  0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i].v * HTOT + vecs[i].h);
         check_output($sformatf("vec%0d(%0d,%0d) video_on", i, vecs[i].h, vecs[i].v),
                      int'(video_on), int'(vecs[i].exp_video));
         check_output($sformatf("vec%0d(%0d,%0d) hsync", i, vecs[i].h, vecs[i].v),
                      int'(hsync), int'(vecs[i].exp_hsync));
         check_output($sformatf("vec%0d(%0d,%0d) vsync", i, vecs[i].h, vecs[i].v),
                      int'(vsync), int'(vecs[i].exp_vsync));
         check_output($sformatf("vec%0d(%0d,%0d) rgb", i, vecs[i].h, vecs[i].v),
                      int'(rgb), int'(vecs[i].exp_rgb));
         check_output($sformatf("vec%0d(%0d,%0d) addr", i, vecs[i].h, vecs[i].v),
                      int'(addr), vecs[i].exp_addr);
         check_output($sformatf("vec%0d(%0d,%0d) vblank", i, vecs[i].h, vecs[i].v),
                      int'(vblank_start), int'(vecs[i].exp_vblank));
      end

      // One full frame of per-clock monitoring: sync widths, vblank pulses, address walk.
      prev_addr = int'(addr);
      incs      = 0;
      wraps     = 0;
      jumps     = 0;
      hs_low    = 0;
      vs_low    = 0;
      vb_count  = 0;
      for (int c = 0; c < FRAME_CLKS; c++) begin
         @(negedge clk);
         if (!hsync) hs_low++;
         if (!vsync) vs_low++;
         if (vblank_start) vb_count++;
         if (int'(addr) != prev_addr) begin
            if (int'(addr) == prev_addr + 1) incs++;
            else if (int'(addr) == 0 && prev_addr == COLS*ROWS-1) wraps++;
            else jumps++;
            prev_addr = int'(addr);
         end
      end
      cur += FRAME_CLKS / CPP;
      check_output("frame hsync low clocks", hs_low, VTOT * HSW * CPP);
      check_output("frame vsync low clocks", vs_low, VSW * HTOT * CPP);
      check_output("frame vblank pulses", vb_count, 1);
      check_output("frame addr increments", incs, COLS*ROWS - 1);
      check_output("frame addr wraps", wraps, 1);
      check_output("frame addr jumps", jumps, 0);

      // Asynchronous reset in the middle of a visible line, then a clean restart.
      apply_stimulus(2 * HTOT * VTOT + HTOT + 1);
      check_output("pre-reset rgb", int'(rgb), 12'hFC4);
      #2 reset_n = 1'b0;
      #1 check_reset_values("midline reset");
      @(negedge clk);
      reset_n = 1'b1;
      cur = -1;
      apply_stimulus(0);
      check_output("restart (0,0) rgb", int'(rgb), 12'hFC4);
      check_output("restart (0,0) video_on", int'(video_on), 1);
      check_output("restart (0,0) addr", int'(addr), 1);
      apply_stimulus(COLS + HFP);
      check_output("restart hsync start", int'(hsync), 0);
      apply_stimulus(COLS + HFP + HSW);
      check_output("restart hsync end", int'(hsync), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
